rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource (e.g. a shared gate/ALU datapath) among N requesters.
- Grants are one-hot, registered, and held until the owner releases.
- Fairness comes from a rotating priority pointer.
- Sits between requester blocks and the shared datapath select mux; gnt_id drives the mux.

---
 rtl/rr_arbiter_if.sv | 24 ++
 rtl/rr_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           any_req;
  logic           timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, busy, any_req, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, any_req, timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with held one-hot grants and rotating priority.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT grant cycles.
module rr_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [N-1:0]   gnt_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] ptr;
  logic           busy_q;

  logic [IDW-1:0] nxt_ptr;
  logic [IDW-1:0] arb_ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] jj;
  logic [N-1:0]   arb_req;
  logic           found;
  logic           owner_rel;
  logic           forced;
  logic           rel;

  if (IDW != $clog2(N) || TIMEOUT < 2) begin : g_bad_cfg
    $error("rr_arbiter: bad parameters");
  end

  assign nxt_ptr   = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
  assign owner_rel = bus.done | ~bus.req[id_q];
  assign rel       = (state == GRANT) & (owner_rel | forced);

  // On release the old owner is masked so it cannot win back-to-back.
  always_comb begin
    arb_req = bus.req;
    arb_ptr = ptr;
    if (state == GRANT) begin
      arb_req[id_q] = 1'b0;
      arb_ptr       = nxt_ptr;
    end
    found = 1'b0;
    win   = '0;
    jj    = '0;
    for (int k = 0; k < N; k++) begin
      jj = IDW'((int'(arb_ptr) + k) % N);
      if (!found && arb_req[jj]) begin
        found = 1'b1;
        win   = jj;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt_q  <= '0;
      id_q   <= '0;
      busy_q <= 1'b0;
      ptr    <= '0;
    end else begin
      if (rel)
        ptr <= nxt_ptr;
      if (state == IDLE || rel) begin
        unique case (1'b1)
          found: begin
            state  <= GRANT;
            gnt_q  <= N'(1) << win;
            id_q   <= win;
            busy_q <= 1'b1;
          end
          default: begin
            state  <= IDLE;
            gnt_q  <= '0;
            id_q   <= '0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] hold;
  logic          to_q;

  // A real release on the expiry cycle wins, so no pulse then.
  assign forced = (hold == CW'(TIMEOUT - 1)) & ~owner_rel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      to_q <= 1'b0;
    end else begin
      to_q <= (state == GRANT) & forced;
      if (state != GRANT || rel)
        hold <= '0;
      else
        hold <= hold + 1'b1;
    end
  end

  assign bus.timeout = to_q;
`else
  assign forced      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.busy    = busy_q;
  assign bus.any_req = |bus.req;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: expected grant owners are queued as
// stimulus is applied and checked after each clock edge.
module tb_rr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   exp_q[$];

  rr_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  rr_arbiter #(
    .N(N),
    .IDW(IDW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // -1 in the queue means idle: no grant, not busy, gnt_id 0.
  task automatic tick(input logic to_exp);
    int e;
    logic [N-1:0] g;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard empty observed=%0h expected=none", bus.gnt);
    end else begin
      e = exp_q.pop_front();
      if (e < 0) begin
        chk("idle_gnt", 32'(bus.gnt), 32'(0));
        chk("idle_id", 32'(bus.gnt_id), 32'(0));
        chk("idle_busy", 32'(bus.busy), 32'(0));
      end else begin
        g = '0;
        g[e] = 1'b1;
        chk("gnt", 32'(bus.gnt), 32'(g));
        chk("gnt_id", 32'(bus.gnt_id), 32'(e));
        chk("busy", 32'(bus.busy), 32'(1));
      end
    end
    chk("timeout", 32'(bus.timeout), 32'(to_exp));
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b1111;
    bus.done = 1'b0;

    // reset held with all requests pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_id", 32'(bus.gnt_id), 32'(0));
    chk("rst_to", 32'(bus.timeout), 32'(0));
    chk("any_req", 32'(bus.any_req), 32'(1));

    // single request, then done
    rst_n   = 1'b1;
    bus.req = 4'b0100;
    exp_q.push_back(2);
    tick(1'b0);
    bus.done = 1'b1;
    exp_q.push_back(-1);
    tick(1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    #1;
    chk("any_req0", 32'(bus.any_req), 32'(0));
    exp_q.push_back(-1);
    tick(1'b0);

    // ptr=3: skip and wrap to 0, then 1
    bus.req = 4'b0011;
    exp_q.push_back(0);
    tick(1'b0);
    bus.done = 1'b1;
    exp_q.push_back(1);
    tick(1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    exp_q.push_back(-1);
    tick(1'b0);

    // asynchronous reset in the middle of a grant
    bus.req = 4'b1111;
    exp_q.push_back(2);
    tick(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(bus.gnt), 32'(0));
    chk("async_busy", 32'(bus.busy), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // round robin with no idle cycles
    bus.done = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    repeat (5) tick(1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    exp_q.push_back(-1);
    tick(1'b0);

    // owner 1 withdraws; 3 wins next
    bus.req = 4'b0010;
    exp_q.push_back(1);
    tick(1'b0);
    bus.req = 4'b1001;
    exp_q.push_back(3);
    tick(1'b0);
    bus.req = 4'b0000;
    exp_q.push_back(-1);
    tick(1'b0);

    // new requests never preempt the owner
    bus.req = 4'b0001;
    exp_q.push_back(0);
    tick(1'b0);
    bus.req = 4'b1111;
    repeat (3) begin
      exp_q.push_back(0);
      tick(1'b0);
    end

    // hold limit
    rst_n = 1'b0;
    #1;
    chk("rst2_gnt", 32'(bus.gnt), 32'(0));
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    bus.req = 4'b0011;
    exp_q.push_back(0);
    tick(1'b0);
`ifdef ARB_TIMEOUT_EN
    repeat (TO - 1) begin
      exp_q.push_back(0);
      tick(1'b0);
    end
    exp_q.push_back(1);
    tick(1'b1);
    exp_q.push_back(1);
    tick(1'b0);
`else
    repeat (100) begin
      exp_q.push_back(0);
      tick(1'b0);
    end
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
